// File: rtl/guess_entry_if.sv
// -----------------------------------------------------------------------------
// guess_entry_if
//   Bundles the key/switch inputs and the display/scoring outputs of the guess
//   entry controller.
//   master : debounced key/switch source side (drives digitIn and the pulses)
//   slave  : guess_entry_ctrl side (drives guess, slotBlank, cursor, full,
//            guessValid)
//   Signals:
//     digitIn    [1:0]            digit value from the switches
//     enter/clear/submit/newRound one-cycle command pulses
//     guess      [2*NUM_SLOTS-1:0] slot i digit = guess[2i+1:2i]
//     slotBlank  [NUM_SLOTS-1:0]   1 = blank slot i
//     cursor     [2:0]             next slot to fill
//     full                         all slots filled, awaiting submit
//     guessValid                   one-cycle pulse when a guess is handed over
// -----------------------------------------------------------------------------
interface guess_entry_if #(
  parameter int NUM_SLOTS = 4
);
  logic [1:0]             digitIn;
  logic                   enter;
  logic                   clear;
  logic                   submit;
  logic                   newRound;
  logic [2*NUM_SLOTS-1:0] guess;
  logic [NUM_SLOTS-1:0]   slotBlank;
  logic [2:0]             cursor;
  logic                   full;
  logic                   guessValid;

  modport master (
    output digitIn, enter, clear, submit, newRound,
    input  guess, slotBlank, cursor, full, guessValid
  );

  modport slave (
    input  digitIn, enter, clear, submit, newRound,
    output guess, slotBlank, cursor, full, guessValid
  );
endinterface

// File: rtl/guess_entry_ctrl.sv
// -----------------------------------------------------------------------------
// guess_entry_ctrl
//   Sequences player guess entry onto a bank of per-slot HEX digit displays.
//   Each enter pulse stores digitIn into the slot under the cursor; once every
//   slot is filled a submit pulse hands the guess to the scoring logic with a
//   one-cycle guessValid and locks the entry until newRound.
//
//   Ports:
//     clk    system clock
//     Reset  synchronous, active-high reset
//     bus    guess_entry_if.slave (commands in, guess/blank/cursor/status out)
//
//   Parameters:
//     NUM_SLOTS  number of guess digits / display slots (2..8)
//     BLINK_DIV  blink counter width; blink phase is the counter MSB
//
//   Build option:
//     CURSOR_BLINK_EN  when defined, the slot under the cursor previews digitIn
//                      live and blinks using a free-running BLINK_DIV-bit
//                      counter. Stored digits are never affected by the
//                      preview, and FULL/LOCKED do not blink.
//
//   All outputs are registered (one-cycle latency from the sampling edge).
// -----------------------------------------------------------------------------
module guess_entry_ctrl #(
  parameter int NUM_SLOTS = 4,
  parameter int BLINK_DIV = 24
) (
  input  logic         clk,
  input  logic         Reset,
  guess_entry_if.slave bus
);

  localparam int GW = 2 * NUM_SLOTS;

  // Catch unsupported configurations at elaboration time.
  if (NUM_SLOTS < 2 || NUM_SLOTS > 8 || BLINK_DIV < 1) begin : g_bad_param
    $error("guess_entry_ctrl: NUM_SLOTS must be 2..8 and BLINK_DIV >= 1");
  end

  typedef enum logic [1:0] {
    ENTRY  = 2'd0,
    FULL   = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e               state_q,  state_d;
  logic [GW-1:0]        guess_q,  guess_d;   // stored digits
  logic [NUM_SLOTS-1:0] blank_q,  blank_d;   // stored blank flags
  logic [2:0]           cursor_q, cursor_d;
  logic                 full_q,   full_d;
  logic                 valid_q,  valid_d;

  // Next-state logic. Command priority: clear > newRound > submit > enter.
  // NOTE: every variable written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    blank_d  = blank_q;
    cursor_d = cursor_q;
    full_d   = full_q;
    valid_d  = 1'b0;

    if (bus.clear && state_q != LOCKED) begin
      state_d  = ENTRY;
      guess_d  = '0;
      blank_d  = '1;
      cursor_d = 3'd0;
      full_d   = 1'b0;
    end else if (bus.newRound && state_q == LOCKED) begin
      state_d  = ENTRY;
      guess_d  = '0;
      blank_d  = '1;
      cursor_d = 3'd0;
      full_d   = 1'b0;
    end else if (bus.submit && state_q == FULL) begin
      // Leaving FULL for LOCKED guarantees guessValid cannot repeat.
      state_d = LOCKED;
      full_d  = 1'b0;
      valid_d = 1'b1;
    end else if (bus.enter && state_q == ENTRY) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (cursor_q == 3'(i)) begin
          guess_d[2*i +: 2] = bus.digitIn;
          blank_d[i]        = 1'b0;
        end
      end
      // With 8 slots the 3-bit cursor reads 0 once full; `full` disambiguates.
      cursor_d = cursor_q + 3'd1;
      if (cursor_q == 3'(NUM_SLOTS - 1)) begin
        state_d = FULL;
        full_d  = 1'b1;
      end
    end
  end

  // NOTE: Reset is sampled synchronously here, so it only needs to meet setup
  // like any other input; all state uses non-blocking assignments so every
  // flop sees pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q  <= ENTRY;
      guess_q  <= '0;
      blank_q  <= '1;
      cursor_q <= 3'd0;
      full_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      blank_q  <= blank_d;
      cursor_q <= cursor_d;
      full_q   <= full_d;
      valid_q  <= valid_d;
    end
  end

`ifdef CURSOR_BLINK_EN
  // Blink counter restarts on every user command so the cursor slot always
  // begins a fresh blank phase right after the player acts.
  logic [BLINK_DIV-1:0] blink_q, blink_d;
  logic [GW-1:0]        gout_q,  gout_d;     // displayed digits (with preview)
  logic [NUM_SLOTS-1:0] bout_q,  bout_d;     // displayed blanks (with blink)

  always_comb begin
    if (bus.clear || bus.newRound || bus.enter) begin
      blink_d = '0;
    end else begin
      blink_d = blink_q + {{(BLINK_DIV-1){1'b0}}, 1'b1};
    end

    // Overlay the live preview on top of the next stored values; the stored
    // registers themselves are untouched.
    gout_d = guess_d;
    bout_d = blank_d;
    if (state_d == ENTRY) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (cursor_d == 3'(i)) begin
          gout_d[2*i +: 2] = bus.digitIn;
          bout_d[i]        = ~blink_d[BLINK_DIV-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      blink_q <= '0;
      gout_q  <= '0;
      bout_q  <= '1;
    end else begin
      blink_q <= blink_d;
      gout_q  <= gout_d;
      bout_q  <= bout_d;
    end
  end

  assign bus.guess     = gout_q;
  assign bus.slotBlank = bout_q;
`else
  // Unfilled slots simply stay blank with digit 0.
  assign bus.guess     = guess_q;
  assign bus.slotBlank = blank_q;
`endif

  assign bus.cursor     = cursor_q;
  assign bus.full       = full_q;
  assign bus.guessValid = valid_q;

endmodule

// File: tb/tb_guess_entry_ctrl.sv
// -----------------------------------------------------------------------------
// tb_guess_entry_ctrl
//   Directed self-checking bench for guess_entry_ctrl with NUM_SLOTS=4.
//   Inputs change 1 ns after the rising edge; outputs are observed at that
//   same point, i.e. after the registered update of the preceding edge.
//   Builds with BLINK_DIV=3 when CURSOR_BLINK_EN is defined.
// -----------------------------------------------------------------------------
module tb_guess_entry_ctrl;

  localparam int NUM_SLOTS = 4;
`ifdef CURSOR_BLINK_EN
  localparam int BLINK_DIV = 3;
  localparam bit BLINK     = 1'b1;
`else
  localparam int BLINK_DIV = 24;
  localparam bit BLINK     = 1'b0;
`endif

  logic clk;
  logic Reset;

  guess_entry_if #(.NUM_SLOTS(NUM_SLOTS)) bus ();

  guess_entry_ctrl #(
    .NUM_SLOTS(NUM_SLOTS),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk  (clk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.enter    = 1'b0;
    bus.clear    = 1'b0;
    bus.submit   = 1'b0;
    bus.newRound = 1'b0;
  endtask

  task automatic do_enter(input logic [1:0] d);
    bus.digitIn = d;
    bus.enter   = 1'b1;
    step();
    bus.enter   = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_g0;

    Reset = 1'b1;
    bus.digitIn = 2'd0;
    idle_inputs();

    // 1: reset state
    step();
    Reset = 1'b0;
    check("rst_blank",  32'(bus.slotBlank),  32'hF);
    check("rst_guess",  32'(bus.guess),      32'h0);
    check("rst_cursor", 32'(bus.cursor),     32'd0);
    check("rst_full",   32'(bus.full),       32'd0);
    check("rst_valid",  32'(bus.guessValid), 32'd0);

    // 2: fill all four slots with 3,1,2,0
    do_enter(2'd3);
    check("e1_cursor", 32'(bus.cursor),    32'd1);
    check("e1_blank",  32'(bus.slotBlank), 32'hE);
    check("e1_full",   32'(bus.full),      32'd0);
    do_enter(2'd1);
    do_enter(2'd2);
    check("e3_full",   32'(bus.full),      32'd0);
    do_enter(2'd0);
    check("e4_guess",  32'(bus.guess),     32'h27);
    check("e4_blank",  32'(bus.slotBlank), 32'h0);
    check("e4_cursor", 32'(bus.cursor),    32'd4);
    check("e4_full",   32'(bus.full),      32'd1);

    // 3: enter ignored in FULL
    do_enter(2'd2);
    check("full_enter_guess",  32'(bus.guess),      32'h27);
    check("full_enter_cursor", 32'(bus.cursor),     32'd4);
    check("full_enter_valid",  32'(bus.guessValid), 32'd0);

    // submit + enter together: submit wins
    bus.digitIn = 2'd1;
    bus.submit  = 1'b1;
    bus.enter   = 1'b1;
    step();
    idle_inputs();
    check("submit_valid", 32'(bus.guessValid), 32'd1);
    check("submit_full",  32'(bus.full),       32'd0);
    check("submit_guess", 32'(bus.guess),      32'h27);
    step();
    check("valid_pulse_end", 32'(bus.guessValid), 32'd0);

    // LOCKED: submit, enter, clear each ignored
    bus.submit = 1'b1;
    step();
    idle_inputs();
    check("lock_submit_valid", 32'(bus.guessValid), 32'd0);
    bus.enter = 1'b1;
    step();
    idle_inputs();
    check("lock_enter_guess", 32'(bus.guess),  32'h27);
    check("lock_enter_cursor", 32'(bus.cursor), 32'd4);
    bus.clear = 1'b1;
    step();
    idle_inputs();
    check("lock_clear_guess", 32'(bus.guess),     32'h27);
    check("lock_clear_blank", 32'(bus.slotBlank), 32'h0);

    // newRound releases LOCKED
    bus.digitIn  = 2'd0;
    bus.newRound = 1'b1;
    step();
    idle_inputs();
    check("nr_blank",  32'(bus.slotBlank), 32'hF);
    check("nr_cursor", 32'(bus.cursor),    32'd0);
    check("nr_guess",  32'(bus.guess),     32'h0);
    check("nr_valid",  32'(bus.guessValid), 32'd0);

    // 4: two digits, then clear+enter together: clear wins, digit dropped
    do_enter(2'd1);
    do_enter(2'd2);
    check("pre_clear_cursor", 32'(bus.cursor), 32'd2);
    bus.digitIn = 2'd3;
    bus.clear   = 1'b1;
    bus.enter   = 1'b1;
    step();
    idle_inputs();
    // With the preview enabled, slot 0 shows the live switch value.
    exp_g0 = BLINK ? 2'd3 : 2'd0;
    check("clr_blank",  32'(bus.slotBlank), 32'hF);
    check("clr_cursor", 32'(bus.cursor),    32'd0);
    check("clr_guess",  32'(bus.guess),     32'(exp_g0));

    // 5: submit before full is ignored; Reset mid-entry gives reset values
    do_enter(2'd2);
    do_enter(2'd1);
    bus.submit = 1'b1;
    step();
    idle_inputs();
    check("early_submit_valid",  32'(bus.guessValid), 32'd0);
    check("early_submit_cursor", 32'(bus.cursor),     32'd2);
    check("early_submit_full",   32'(bus.full),       32'd0);
    do_enter(2'd3);
    check("pre_rst_cursor", 32'(bus.cursor), 32'd3);
    bus.digitIn = 2'd0;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("mid_rst_valid",  32'(bus.guessValid), 32'd0);
    check("mid_rst_cursor", 32'(bus.cursor),     32'd0);
    check("mid_rst_blank",  32'(bus.slotBlank),  32'hF);
    check("mid_rst_guess",  32'(bus.guess),      32'h0);
    step();
    check("post_rst_valid", 32'(bus.guessValid), 32'd0);

`ifdef CURSOR_BLINK_EN
    // 6: cursor at slot 1 previews digitIn=2 and blinks with a 4-cycle phase
    do_enter(2'd1);
    bus.digitIn = 2'd2;
    for (int k = 1; k <= 8; k++) begin
      logic [2:0] cnt;
      cnt = 3'(k);
      step();
      check("blink_blank1", 32'(bus.slotBlank[1]), 32'(~cnt[2]));
      check("blink_guess1", 32'(bus.guess[3:2]),   32'd2);
    end
    do_enter(2'd2);
    check("blink_enter_blank1", 32'(bus.slotBlank[1]), 32'd0);
    check("blink_enter_guess1", 32'(bus.guess[3:2]),   32'd2);
    check("blink_enter_cursor", 32'(bus.cursor),       32'd2);
    check("blink_enter_blank2", 32'(bus.slotBlank[2]), 32'd1);
    check("blink_enter_guess2", 32'(bus.guess[5:4]),   32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
